key_write_sequencer: RTL and testbench

- Upstream front end for the 4 x 8-bit load-register bank. It turns one board push-button press into exactly one single-cycle register write.
- It synchronizes and debounces the active-low key, then samples the switches for target address and data.
- It drives a one-hot load vector plus an 8-bit data bus straight into the register bank's ld/d inputs.
- It also reports busy status and a wrapping write counter for LED display.

---
 rtl/key_write_sequencer.sv | 122 ++++++++++++
 tb/tb_key_write_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_write_sequencer.sv
// Push-button front end for the 4 x 8-bit load-register bank.
// Sync + debounce KEY_N, one one-hot ld pulse per press, busy + wr_count.
//
// Ports:
//   CLOCK_50  system clock
//   RESET_N   async active-low reset
//   KEY_N     raw push-button, 0 = pressed
//   SW        [9:8] target address, [7:0] write data
//   ld        one-hot load strobe, one cycle per accepted press
//   d         write data, holds last written value
//   busy      press accepted, release not yet accepted
//   wr_count  writes issued, modulo 256
module key_write_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_N,
  input  logic [9:0] SW,
  output logic [3:0] ld,
  output logic [7:0] d,
  output logic       busy,
  output logic [7:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             key_db;
  logic             key_db_q;
  logic [CNT_W-1:0] cnt;
  logic             press_evt;
  logic             rel_evt;
  state_t           state;
  state_t           state_nx;
  logic [1:0]       addr;
  logic [7:0]       data;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= KEY_N;
      sync2 <= sync1;
    end
  end

  // Counter only runs while the synced key disagrees with the
  // accepted level; any agreement restarts it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      cnt      <= '0;
    end else begin
      key_db_q <= key_db;
      if (sync2 == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_db <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press_evt = key_db_q & ~key_db;
  assign rel_evt   = ~key_db_q & key_db;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      addr     <= '0;
      data     <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && press_evt) begin
        addr <= SW[9:8];
        data <= SW[7:0];
      end
      if (state == WRITE) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ld       = 4'b0000;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_evt) state_nx = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        ld       = 4'b0001 << addr;
        // A release accepted during the write cycle must not be lost.
        state_nx = rel_evt ? IDLE : WAIT_REL;
      end
      WAIT_REL: begin
        busy = 1'b1;
        if (rel_evt) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign d = data;

endmodule

// File: tb/tb_key_write_sequencer.sv
// Scoreboard bench for key_write_sequencer.
// Stimulus queues expected writes; a negedge monitor checks each ld pulse.
module tb_key_write_sequencer;

  localparam int DEB = 4;
  // Edges from a key change (driven just after an edge) to the edge
  // that starts the write cycle: 2 sync, DEB debounce, 1 event.
  // The monitor samples at the negedge inside that cycle, i.e. before
  // the 2+DEB+2'th rising edge captures ld.
  localparam int LAT = 2 + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [9:0] sw = '0;
  logic [3:0] ld;
  logic [7:0] d;
  logic       busy;
  logic [7:0] wr_count;

  key_write_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .KEY_N(key_n),
    .SW(sw),
    .ld(ld),
    .d(d),
    .busy(busy),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] ld;
    logic [7:0] d;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_cnt = '0;
  logic       chk_cnt = 1'b0;
  logic [7:0] cnt_exp = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int t);
    while (cyc < t) tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] dat,
                      input logic [7:0] c, input int t);
    exp_t e;
    e.ld  = 4'b0001 << a;
    e.d   = dat;
    e.cnt = c;
    e.cyc = t;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_cnt = 1'b0;
      end else begin
        if (chk_cnt) begin
          chk("wr_count", {24'd0, wr_count}, {24'd0, cnt_exp});
          chk_cnt = 1'b0;
        end
        if (ld != 4'b0000) begin
          if (q.size() == 0) begin
            chk("unexpected_ld", {28'd0, ld}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("ld", {28'd0, ld}, {28'd0, e.ld});
            chk("d", {24'd0, d}, {24'd0, e.d});
            chk("latency", cyc, e.cyc);
            cnt_exp = e.cnt;
            chk_cnt = 1'b1;
          end
        end
      end
    end
  end

  task automatic release_key();
    int r;
    key_n = 1'b1;
    r = cyc;
    at_neg(r + LAT - 1);
    chk("busy_before_rel", {31'd0, busy}, 32'd1);
    at_neg(r + LAT);
    chk("busy_after_rel", {31'd0, busy}, 32'd0);
    tick(2);
  endtask

  task automatic write_timeout(input int f);
    at_neg(f + LAT + 2);
    chk("ld_timeout", q.size(), 32'd0);
    q.delete();
    chk("busy_held", {31'd0, busy}, 32'd1);
    tick();
  endtask

  task automatic press(input logic [1:0] a, input logic [7:0] dat,
                       input int hold, input bit bounce);
    int f;
    if (bounce) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        key_n = 1'b0;
        tick(int'($urandom_range(1, DEB - 1)));
        key_n = 1'b1;
        tick(int'($urandom_range(1, 3)));
      end
    end
    sw = {a, dat};
    key_n = 1'b0;
    f = cyc;
    model_cnt = model_cnt + 8'd1;
    push(a, dat, model_cnt, f + LAT);
    write_timeout(f);
    sw = $urandom_range(0, 1) ? 10'h3FF : 10'($urandom);
    at_neg(f + hold);
    chk("d_held", {24'd0, d}, {24'd0, dat});
    chk("no_rewrite", {24'd0, wr_count}, {24'd0, model_cnt});
    tick();
    release_key();
  endtask

  initial begin
    int f;
    tick(3);
    chk("reset_outs", {11'd0, ld, d, busy, wr_count}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(4);
      chk("idle_outs", {11'd0, ld, d, busy, wr_count}, 32'd0);
    end

    press(2'b10, 8'hA5, 20, 1'b0);

    for (int i = 0; i < 8; i++) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(2);
    end
    tick(10);
    chk("bounce_count", {24'd0, wr_count}, {24'd0, model_cnt});
    chk("bounce_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++)
      press(2'(i), 8'(8'h11 * (i + 1)), 14, 1'b0);
    chk("four_count", {24'd0, wr_count}, 32'd5);

    sw = {2'b11, 8'h5A};
    key_n = 1'b0;
    f = cyc;
    push(2'b11, 8'h5A, model_cnt + 8'd1, f + LAT);
    write_timeout(f);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {11'd0, ld, d, busy, wr_count}, 32'd0);
    model_cnt = '0;
    tick(3);
    chk("inrst_outs", {11'd0, ld, d, busy, wr_count}, 32'd0);
    rst_n = 1'b1;
    f = cyc;
    model_cnt = 8'd1;
    push(2'b11, 8'h5A, model_cnt, f + LAT);
    at_neg(f + LAT - 1);
    chk("postrst_idle", {31'd0, busy}, 32'd0);
    tick();
    write_timeout(f);
    release_key();
    chk("postrst_count", {24'd0, wr_count}, 32'd1);

    for (int i = 0; i < 255; i++)
      press(2'($urandom), 8'($urandom),
            int'($urandom_range(LAT + 4, LAT + 10)),
            1'($urandom_range(0, 1)));
    tick(4);
    chk("wrap", {24'd0, wr_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
